// File: rtl/register_file_pkg.sv
// Shared sizing defaults and constants for the datapath register file.
package register_file_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

    function automatic int unsigned reg_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/register_file_read_mux.sv
// One combinational read port; address ZERO_REG always reads as zero.
module register_file_read_mux
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 32'd1 << ADDR_W
) (
    input  logic [DATA_W-1:0] regs_i [DEPTH],
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    // Storage for reg 0 is undefined before the first reset, so mask it here.
    always_comb begin
        data_o = regs_i[addr_i];
        if (addr_i == ADDR_W'(ZERO_REG)) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 2^ADDR_W x DATA_W register file: two combinational read ports, one synchronous write port.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] x_read,
    input  logic [ADDR_W-1:0] y_read,
    input  logic [ADDR_W-1:0] z_write,
    input  logic [DATA_W-1:0] z_data,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out
);

    localparam int unsigned DEPTH = reg_depth(ADDR_W);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (z_write != ADDR_W'(ZERO_REG))) begin
            regs_d[z_write] = z_data;
        end
    end

    // Reset wins over a same-edge write, discarding it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    register_file_read_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_x_mux (
        .regs_i (regs_q),
        .addr_i (x_read),
        .data_o (x_out)
    );

    register_file_read_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_y_mux (
        .regs_i (regs_q),
        .addr_i (y_read),
        .data_o (y_out)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array-based reference model.
module tb_register_file;

    logic        clock;
    logic        reset;
    logic [4:0]  x_read;
    logic [4:0]  y_read;
    logic [4:0]  z_write;
    logic [31:0] z_data;
    logic        RegWrite;
    logic [31:0] x_out;
    logic [31:0] y_out;

    int checks;
    int failures;
    logic [31:0] model [32];

    register_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .x_read   (x_read),
        .y_read   (y_read),
        .z_write  (z_write),
        .z_data   (z_data),
        .RegWrite (RegWrite),
        .x_out    (x_out),
        .y_out    (y_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    // Advance one rising edge, applying the architectural rules to the model.
    task automatic cycle();
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (RegWrite && z_write != 5'd0) begin
            model[z_write] = z_data;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1;
        z_write  = a;
        z_data   = d;
        cycle();
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        RegWrite = 1'b0;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            x_read = 5'(i);
            y_read = 5'(31 - i);
            #1;
            checks++;
            if (x_out !== 32'd0) begin
                failures++;
                $display("FAIL reset_x addr=%0d got=%h want=0", i, x_out);
            end
            checks++;
            if (y_out !== 32'd0) begin
                failures++;
                $display("FAIL reset_y addr=%0d got=%h want=0", 31 - i, y_out);
            end
        end
    endtask

    task automatic test_basic_writes();
        logic [4:0]  addrs [3];
        logic [31:0] exps  [3];
        do_write(5'd4, 32'd32);
        do_write(5'd16, 32'd24);
        addrs[0] = 5'd4;  exps[0] = 32'd32;
        addrs[1] = 5'd16; exps[1] = 32'd24;
        addrs[2] = 5'd20; exps[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            x_read = addrs[i];
            #1;
            checks++;
            if (x_out !== exps[i]) begin
                failures++;
                $display("FAIL basic_x addr=%0d got=%0d want=%0d", addrs[i], x_out, exps[i]);
            end
        end
    endtask

    task automatic test_dual_read();
        x_read = 5'd16; y_read = 5'd16;
        #1;
        checks++;
        if (x_out !== 32'd24 || y_out !== 32'd24) begin
            failures++;
            $display("FAIL same_addr got x=%0d y=%0d want 24/24", x_out, y_out);
        end
        x_read = 5'd4; y_read = 5'd16;
        #1;
        checks++;
        if (x_out !== 32'd32 || y_out !== 32'd24) begin
            failures++;
            $display("FAIL split_addr got x=%0d y=%0d want 32/24", x_out, y_out);
        end
    endtask

    task automatic test_reg0_and_disable();
        do_write(5'd0, 32'hDEADBEEF);
        x_read = 5'd0; y_read = 5'd0;
        #1;
        checks++;
        if (x_out !== 32'd0 || y_out !== 32'd0) begin
            failures++;
            $display("FAIL reg0 got x=%h y=%h want 0/0", x_out, y_out);
        end
        RegWrite = 1'b0; z_write = 5'd5; z_data = 32'd7;
        cycle();
        x_read = 5'd5;
        #1;
        checks++;
        if (x_out !== 32'd0) begin
            failures++;
            $display("FAIL we_low got=%0d want=0", x_out);
        end
    endtask

    task automatic test_read_during_write();
        x_read = 5'd4;
        RegWrite = 1'b1; z_write = 5'd4; z_data = 32'd99;
        #1;
        checks++;
        if (x_out !== 32'd32) begin
            failures++;
            $display("FAIL rdw_before got=%0d want=32", x_out);
        end
        cycle();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (x_out !== 32'd99) begin
            failures++;
            $display("FAIL rdw_after got=%0d want=99", x_out);
        end
    endtask

    task automatic test_reset_priority();
        logic [4:0] addrs [3];
        do_write(5'd8, 32'd77);
        reset = 1'b1;
        RegWrite = 1'b1; z_write = 5'd8; z_data = 32'd5;
        cycle();
        reset = 1'b0;
        RegWrite = 1'b0;
        addrs[0] = 5'd8; addrs[1] = 5'd4; addrs[2] = 5'd16;
        for (int i = 0; i < 3; i++) begin
            y_read = addrs[i];
            #1;
            checks++;
            if (y_out !== 32'd0) begin
                failures++;
                $display("FAIL reset_prio addr=%0d got=%0d want=0", addrs[i], y_out);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            reset    = ($urandom_range(0, 39) == 0);
            RegWrite = $urandom_range(0, 3) != 0;
            z_write  = 5'($urandom_range(0, 31));
            z_data   = $urandom;
            x_read   = ($urandom_range(0, 2) == 0) ? z_write : 5'($urandom_range(0, 31));
            y_read   = 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (x_out !== model_read(x_read) || y_out !== model_read(y_read)) begin
                failures++;
                $display("FAIL random n=%0d x[%0d]=%h want %h y[%0d]=%h want %h",
                         n, x_read, x_out, model_read(x_read), y_read, y_out, model_read(y_read));
            end
            cycle();
        end
        reset = 1'b0;
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            x_read = 5'(i);
            #1;
            checks++;
            if (x_out !== model_read(x_read)) begin
                failures++;
                $display("FAIL random_sweep addr=%0d got=%h want=%h", i, x_out, model_read(x_read));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        RegWrite = 1'b0;
        x_read = '0; y_read = '0; z_write = '0; z_data = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(negedge clock);
        test_reset();
        test_basic_writes();
        test_dual_read();
        test_reg0_and_disable();
        test_read_during_write();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
